// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter that locks ownership for a whole cyc envelope.
// Optional stalled-strobe watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state, state_next;
  logic   last, last_next;
  logic   tout;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;
  logic          owner_cyc, owner_stb, term, stall;

  assign owner_cyc = (state == OWN0 && m0_cyc_i) || (state == OWN1 && m1_cyc_i);
  assign owner_stb = (state == OWN0 && m0_cyc_i && m0_stb_i) ||
                     (state == OWN1 && m1_cyc_i && m1_stb_i);
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign stall     = owner_stb && !term;
  // The error fires on the stalled cycle that would bring the count to the limit.
  assign tout      = stall && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                        count <= '0;
    else if (!owner_cyc || term || tout) count <= '0;
    else if (owner_stb)                 count <= count + 1'b1;
  end
`else
  assign tout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      last    <= 1'b1;
      grant_o <= 2'b00;
    end else begin
      state   <= state_next;
      last    <= last_next;
      grant_o <= {state_next == OWN1, state_next == OWN0};
    end
  end

  // A dropping owner hands over in the same cycle, so the other master never sees an idle gap.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_next = OWN0;
          last_next  = 1'b0;
        end else if (m1_cyc_i) begin
          state_next = OWN1;
          last_next  = 1'b1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_next = m1_cyc_i ? OWN1 : IDLE;
          if (m1_cyc_i) last_next = 1'b1;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_next = m0_cyc_i ? OWN0 : IDLE;
          if (m0_cyc_i) last_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    m1_dat_o = '0;
    case (state)
      OWN0: begin
        s_cyc_o  = m0_cyc_i & ~tout;
        s_stb_o  = m0_stb_i & ~tout;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | tout;
        m0_rty_o = s_rty_i;
        m0_dat_o = s_dat_i;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i & ~tout;
        s_stb_o  = m1_stb_i & ~tout;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | tout;
        m1_rty_o = s_rty_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed self-checking bench for wishbone_arbiter; read completions are checked against a
// scoreboard queue filled whenever the bench drives a slave acknowledge.
module tb_wishbone_arbiter;

  localparam int AW = 24;

  logic          clk_i, rst_ni;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [7:0]    m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o, grant_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;

  int n_checks = 0;
  int n_fail   = 0;
  int count0   = 0;
  int count1   = 0;
  logic [17:0] exp_q[$];

  wishbone_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic [AW-1:0] adr, input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = 1'b0; m0_adr_i = adr; m0_cti_i = cti;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = 1'b0; m1_adr_i = adr; m1_cti_i = cti;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave acknowledge with read data; the expected owner-side view goes into the scoreboard.
  task automatic slaveAck(input int owner, input logic [7:0] data);
    s_ack_i = 1'b1;
    s_dat_i = data;
    exp_q.push_back({owner == 1, owner == 0, (owner == 1) ? data : 8'h00,
                     (owner == 0) ? data : 8'h00});
  endtask

  task automatic checkAck(input string tag);
    logic [17:0] exp;
    exp = (exp_q.size() == 0) ? '1 : exp_q.pop_front();
    checkOutput(tag, {14'd0, m1_ack_o, m0_ack_o, m1_dat_o, m0_dat_o}, {14'd0, exp});
  endtask

  initial begin
    rst_ni = 1'b0;
    applyStimulus(0, 0, 0, '0, 3'b000);
    applyStimulus(1, 0, 0, '0, 3'b000);
    m0_dat_i = 8'h00; m1_dat_i = 8'h00; m0_bte_i = 2'b00; m1_bte_i = 2'b00;
    s_ack_i = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 8'hA5;
    #1;
    checkOutput("reset_grant", grant_o, 2'b00);
    checkOutput("reset_scyc", s_cyc_o, 1'b0);
    checkOutput("reset_term", {m1_ack_o, m0_ack_o, m1_dat_o, m0_dat_o}, 18'd0);
    tick();
    s_ack_i = 1'b0; s_dat_i = 8'h00;
    rst_ni = 1'b1;
    tick();

    $display("[TB] M0 single read");
    applyStimulus(0, 1, 1, 24'h000200, 3'b000);
    #1;
    checkOutput("m0_latency_scyc", s_cyc_o, 1'b0);
    tick();
    checkOutput("m0_scyc", s_cyc_o, 1'b1);
    checkOutput("m0_grant", grant_o, 2'b01);
    checkOutput("m0_sadr", s_adr_o, 24'h000200);
    slaveAck(0, 8'h5A);
    #1;
    checkAck("m0_read");
    tick();
    s_ack_i = 1'b0;
    applyStimulus(0, 0, 0, 24'h000200, 3'b000);
    #1;
    checkOutput("m0_drop_scyc", s_cyc_o, 1'b0);
    tick();
    checkOutput("m0_idle_grant", grant_o, 2'b00);

    $display("[TB] Simultaneous request after reset");
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    applyStimulus(0, 1, 1, 24'h000111, 3'b000);
    applyStimulus(1, 1, 1, 24'h000222, 3'b000);
    tick();
    checkOutput("tie_grant", grant_o, 2'b01);
    checkOutput("tie_sadr", s_adr_o, 24'h000111);
    slaveAck(0, 8'h33);
    #1;
    checkAck("tie_m0_read");
    tick();
    s_ack_i = 1'b0;
    applyStimulus(0, 0, 0, 24'h000111, 3'b000);
    #1;
    checkOutput("handover_scyc_low", s_cyc_o, 1'b0);
    tick();
    checkOutput("handover_grant", grant_o, 2'b10);
    checkOutput("handover_sadr", s_adr_o, 24'h000222);
    slaveAck(1, 8'h44);
    #1;
    checkAck("tie_m1_read");
    tick();
    s_ack_i = 1'b0;
    applyStimulus(1, 0, 0, 24'h000222, 3'b000);
    tick();

    $display("[TB] M1 burst with M0 waiting");
    applyStimulus(1, 1, 1, 24'h000200, 3'b010);
    tick();
    checkOutput("burst_grant", grant_o, 2'b10);
    applyStimulus(0, 1, 1, 24'h000300, 3'b000);
    slaveAck(1, 8'h61);
    #1;
    checkAck("burst_beat0");
    checkOutput("burst_sadr0", s_adr_o, 24'h000200);
    tick();
    applyStimulus(1, 1, 1, 24'h000201, 3'b111);
    slaveAck(1, 8'h62);
    #1;
    checkOutput("burst_lock_grant", grant_o, 2'b10);
    checkOutput("burst_sadr1", s_adr_o, 24'h000201);
    checkAck("burst_beat1");
    tick();
    s_ack_i = 1'b0;
    applyStimulus(1, 0, 0, 24'h000201, 3'b000);
    tick();
    checkOutput("burst_m0_grant", grant_o, 2'b01);
    checkOutput("burst_m0_sadr", s_adr_o, 24'h000300);
    applyStimulus(0, 0, 0, 24'h000300, 3'b000);
    tick();
    tick();

    $display("[TB] Round-robin over eight envelopes");
    rst_ni = 1'b0;
    #2 rst_ni = 1'b1;
    applyStimulus(0, 1, 1, 24'h000010, 3'b000);
    applyStimulus(1, 1, 1, 24'h000020, 3'b000);
    for (int e = 0; e < 8; e++) begin
      tick();
      if (e > 0) applyStimulus((e - 1) % 2, 1, 1, 24'h000010 + 24'(16 * ((e - 1) % 2)), 3'b000);
      #1;
      checkOutput($sformatf("rr_grant_%0d", e), grant_o, (e % 2 == 0) ? 2'b01 : 2'b10);
      if (grant_o == 2'b01) count0++;
      if (grant_o == 2'b10) count1++;
      slaveAck(e % 2, 8'(8'h80 + e));
      #1;
      checkAck($sformatf("rr_read_%0d", e));
      tick();
      s_ack_i = 1'b0;
      applyStimulus(e % 2, 0, 0, '0, 3'b000);
    end
    applyStimulus(0, 0, 0, '0, 3'b000);
    applyStimulus(1, 0, 0, '0, 3'b000);
    checkOutput("rr_count0", count0, 4);
    checkOutput("rr_count1", count1, 4);
    tick();
    tick();
    checkOutput("rr_idle_grant", grant_o, 2'b00);

    $display("[TB] Async reset mid-transfer");
    applyStimulus(1, 1, 1, 24'h000400, 3'b000);
    tick();
    checkOutput("ar_pre_grant", grant_o, 2'b10);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("ar_scyc", s_cyc_o, 1'b0);
    checkOutput("ar_sstb", s_stb_o, 1'b0);
    checkOutput("ar_grant", grant_o, 2'b00);
    applyStimulus(1, 0, 0, '0, 3'b000);
    tick();
    rst_ni = 1'b1;
    applyStimulus(1, 1, 1, 24'h000500, 3'b000);
    tick();
    checkOutput("ar_regrant", grant_o, 2'b10);
    checkOutput("ar_regrant_scyc", s_cyc_o, 1'b1);
    applyStimulus(1, 0, 0, '0, 3'b000);
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    $display("[TB] Stalled strobe timeout");
    applyStimulus(0, 1, 1, 24'h000600, 3'b000);
    tick();
    for (int c = 1; c < 4; c++) begin
      checkOutput($sformatf("to_err_low_%0d", c), m0_err_o, 1'b0);
      tick();
    end
    checkOutput("to_err_pulse", m0_err_o, 1'b1);
    checkOutput("to_scyc_forced", s_cyc_o, 1'b0);
    tick();
    applyStimulus(0, 0, 0, '0, 3'b000);
    applyStimulus(1, 1, 1, 24'h000700, 3'b000);
    #1;
    checkOutput("to_err_single", m0_err_o, 1'b0);
    tick();
    checkOutput("to_m1_grant", grant_o, 2'b10);
    applyStimulus(1, 0, 0, '0, 3'b000);
    tick();
`endif

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
Two-master, one-slave Wishbone arbiter sharing the 24-bit/8-bit SRAM bus between the host-side master (SPI/debug bridge, M0) and the Levenshtein search engine master (M1). Grants ownership per bus cycle (whole `cyc` envelope, including incremental bursts) using round-robin between the two masters. Routes strobes and data to the slave, and returns termination and read data only to the owner. Sits between the masters and the SRAM controller.

Parameters:
ADDR_WIDTH, 24, address width of masters and slave
TIMEOUT_CYCLES, 255, stalled-strobe limit before forced error (only with WB_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 (host) control
m0_adr_i  in  ADDR_WIDTH  master 0 address
m0_dat_i  in  8  master 0 write data
m0_cti_i  in  3  master 0 cycle type
m0_bte_i  in  2  master 0 burst type
m0_ack_o, m0_err_o, m0_rty_o  out  1 each  master 0 terminations
m0_dat_o  out  8  master 0 read data
m1_*  same set as m0_*  master 1 (engine)
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  8  slave write data
s_cti_o  out  3  slave cycle type
s_bte_o  out  2  slave burst type
s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations
s_dat_i  in  8  slave read data
grant_o  out  2  one-hot current owner ({M1, M0}); 2'b00 when idle

Behaviour:
- States: IDLE, OWN0, OWN1. State is registered. `last` is a 1-bit register holding the most recently granted master.
- Reset (async, `rst_ni` low): state is IDLE and `last` is 1, so M0 wins the first tie.
  - All outputs are 0 during reset: `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, `s_cti_o`, `s_bte_o`, every `m*_ack_o`/`m*_err_o`/`m*_rty_o`/`m*_dat_o`, and `grant_o`.
  - Reset mid-transfer drops `s_cyc_o` immediately, with no clock edge needed.
- IDLE:
  - Only M0 has `cyc` high: go to OWN0 next edge.
  - Only M1 has `cyc` high: go to OWN1 next edge.
  - Both have `cyc` high: grant the master that is not `last`.
  - On a grant, `last` takes the granted index.
  - Arbitration latency is 1 cycle from `cyc` to `s_cyc_o`.
- OWNn:
  - The slave bus is a combinational mux of master n: `s_cyc_o = mn_cyc_i`, `s_stb_o = mn_stb_i`, plus `adr`, `dat`, `we`, `cti` and `bte`.
  - `mn_ack_o`, `mn_err_o` and `mn_rty_o` equal `s_ack_i`, `s_err_i` and `s_rty_i`; `mn_dat_o = s_dat_i`.
  - The non-owner sees all-zero terminations and data.
- Release:
  - Ownership is held while `mn_cyc_i` is high, regardless of `stb`. Bursts (CTI 010 through 111) are never split.
  - When `mn_cyc_i` is low in OWNn, apply the IDLE decision in the same cycle. If the other master requests, go directly to OWN(other); otherwise go to IDLE.
  - The dropped cycle itself drives `s_cyc_o` = 0.
- Fairness: with both masters continuously re-requesting, grants alternate, and neither master waits more than one foreign `cyc` envelope.
- When idle, or when the owner's `cyc` is low, `s_cyc_o` and `s_stb_o` are 0. `s_adr_o` and the other slave data outputs hold the last owner's values or 0; their value is don't-care.
- Termination inputs arriving while IDLE are ignored and never forwarded.
- `grant_o` is registered, one-hot, and reflects the state.

Optional Feature:
WB_ARB_TIMEOUT_EN:
- Defined: an 8+ bit counter (width `$clog2(TIMEOUT_CYCLES+1)`) increments each cycle in which the owner has `stb` high and the slave asserts none of `ack`/`err`/`rty`. The counter clears on any termination, on release, and on reset.
- When the count reaches TIMEOUT_CYCLES:
  - The arbiter drives `mn_err_o` = 1 for exactly one cycle.
  - It forces `s_cyc_o` and `s_stb_o` to 0 that cycle.
  - It clears the counter.
  - The owner then drops `cyc`; release follows the normal rules.
- Undefined: no counter; only slave-originated `err`/`rty` are forwarded.

Test Plan:
- Reset, then M0 only: M0 raises `cyc`/`stb` with read addr 0x000200, and the slave acks with 0x5A one cycle later → `s_cyc_o` rises 1 cycle after `m0_cyc_i`, `m0_ack_o`=1 with `m0_dat_o`=0x5A, `m1_ack_o`=0, and `grant_o`=01.
- Simultaneous first request: both raise `cyc` on the same edge after reset → M0 granted first. M0 drops `cyc` after one ack → next cycle `grant_o`=10 with `s_adr_o`=M1 address, and no IDLE cycle in between.
- Burst lock: M1 runs a 2-beat burst (CTI 010 then 111, addr 0x000200/0x000201) while M0 requests → M0 waits until `m1_cyc_i` falls, then is granted. Slave sees contiguous addresses with no M0 interleave.
- Round-robin: both masters issue back-to-back single transfers for 8 envelopes → grant sequence M0, M1, M0, M1…, exactly 4 each.
- Async reset mid-transfer: assert `rst_ni`=0 while OWN1 with `stb` high → `s_cyc_o`, `s_stb_o` and `grant_o` go to 0 before the next clock edge. After release, a lone M1 request is granted in 1 cycle.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: slave never acks M0 → `m0_err_o` pulses for 1 cycle on the 4th stalled cycle and `s_cyc_o`=0 that cycle. A subsequent M1 request is then granted.
